// File: rtl/car_cmd_rx.sv
`timescale 1ns/1ps
// car_cmd_rx: 8N1 UART receiver that accepts motion commands 1A/2A/3A/4A and forces stop (2A) when the link watchdog expires
module car_cmd_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int TIMEOUT_MS = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] signal,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       timeout
);
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int TO_CYC = (CLK_HZ / 1000) * TIMEOUT_MS;
  localparam bit WD_EN  = TIMEOUT_MS > 0;
  localparam int WW     = TO_CYC > 0 ? $clog2(TO_CYC + 1) : 1;
  localparam int CW     = $clog2(DIV + 1);
  localparam logic [WW-1:0] LAST     = WD_EN ? WW'(TO_CYC - 1) : '0;
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state;
  logic s1, rxs, tick, byte_rdy, hit;
  logic [CW-1:0] cnt;
  logic [2:0] bitn;
  logic [7:0] sh;
  logic [WW-1:0] wd, wd_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, rxs} <= 2'b11;
    else {s1, rxs} <= {rx, s1};
  always_comb begin
    tick  = cnt == (state == START ? HALF_END : BIT_END);
    hit   = byte_rdy && (sh == 8'h1A || sh == 8'h2A || sh == 8'h3A || sh == 8'h4A);
    wd_nx = wd == LAST ? wd : wd + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bitn      <= '0;
      sh        <= '0;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
      cnt       <= tick ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            bitn  <= '0;
            state <= START;
          end
        end
        START: if (tick) state <= rxs ? IDLE : DATA;
        DATA: if (tick) begin
          sh   <= {rxs, sh[7:1]};
          bitn <= bitn + 1'b1;
          if (bitn == 3'd7) state <= STOP;
        end
        STOP: if (tick) begin
          byte_rdy  <= rxs;
          frame_err <= !rxs;
          state     <= rxs ? IDLE : BRK;
        end
        BRK: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  // a valid command takes priority over a simultaneous watchdog expiry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      signal    <= 8'h2A;
      cmd_valid <= 1'b0;
      timeout   <= 1'b0;
      wd        <= '0;
    end else begin
      cmd_valid <= hit;
      if (hit) begin
        signal  <= sh;
        timeout <= 1'b0;
        wd      <= '0;
      end else if (WD_EN) begin
        wd <= wd_nx;
        if (wd_nx == LAST) begin
          signal  <= 8'h2A;
          timeout <= 1'b1;
        end
      end
    end
endmodule
